// File: rtl/page_flip_controller.sv
// Comic-reader page sequencer: debounced next/prev/auto buttons drive a wrapping page index.
// Define AUTOPLAY_EN to build the AUTO state, its period timer and the btn_auto input path.

module page_flip_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synced input agrees with the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    assign press_o = press_q;
endmodule

// state | meaning
// OFF   | reader disabled, display blanked, page held
// SHOW  | manual paging with next/prev
// AUTO  | page advances every AUTO_PERIOD cycles (AUTOPLAY_EN builds only)
module page_flip_controller #(
    parameter int PAGE_COUNT   = 16,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int AUTO_PERIOD  = 300_000_000
) (
    input  logic       clk100mhz,
    input  logic       rst,
    input  logic       power_on,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_auto,
    output logic [9:0] page,
    output logic       ena,
    output logic       page_stb,
    output logic       auto_on
);
    localparam logic [9:0] PAGE_LAST = 10'(PAGE_COUNT - 1);
    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
`ifdef AUTOPLAY_EN
    localparam logic [1:0] ST_AUTO = 2'd2;
    localparam int TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(AUTO_PERIOD - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          auto_press;
`endif

    logic [1:0] state_q, state_d;
    logic [9:0] page_q, page_d;
    logic       stb_q, stb_d;
    logic       entry;
    logic       next_press, prev_press;
    logic       step_up, step_dn, manual;
    logic [9:0] page_inc, page_dec, manual_page;

    page_flip_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
        .clk_i(clk100mhz), .rst_i(rst), .btn_i(btn_next), .press_o(next_press)
    );
    page_flip_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_prev (
        .clk_i(clk100mhz), .rst_i(rst), .btn_i(btn_prev), .press_o(prev_press)
    );
`ifdef AUTOPLAY_EN
    page_flip_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_auto (
        .clk_i(clk100mhz), .rst_i(rst), .btn_i(btn_auto), .press_o(auto_press)
    );
`else
    logic unused_btn_auto;
    assign unused_btn_auto = btn_auto;
`endif

    // Simultaneous next and prev cancel each other out.
    assign step_up     = next_press & ~prev_press;
    assign step_dn     = prev_press & ~next_press;
    assign manual      = step_up | step_dn;
    assign page_inc    = (page_q == PAGE_LAST) ? 10'd0 : page_q + 10'd1;
    assign page_dec    = (page_q == 10'd0) ? PAGE_LAST : page_q - 10'd1;
    assign manual_page = step_up ? page_inc : page_dec;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        entry   = 1'b0;
`ifdef AUTOPLAY_EN
        timer_d = '0;
`endif
        case (state_q)
            ST_OFF: begin
                if (power_on) begin
                    state_d = ST_SHOW;
                    page_d  = '0;
                    entry   = 1'b1;
                end
            end
            ST_SHOW: begin
                if (manual) page_d = manual_page;
`ifdef AUTOPLAY_EN
                if (auto_press) state_d = ST_AUTO;
`endif
            end
`ifdef AUTOPLAY_EN
            ST_AUTO: begin
                // A manual step wins over a coincident timer expiry and restarts the period.
                if (manual) page_d = manual_page;
                if (auto_press) begin
                    state_d = ST_SHOW;
                end else if (!manual) begin
                    if (timer_q == TMR_LAST) begin
                        page_d = page_inc;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_OFF;
        endcase
        if (!power_on) begin
            state_d = ST_OFF;
            page_d  = page_q;
`ifdef AUTOPLAY_EN
            timer_d = '0;
`endif
        end
        stb_d = entry | (page_d != page_q);
    end

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            state_q <= ST_OFF;
            page_q  <= '0;
            stb_q   <= 1'b0;
`ifdef AUTOPLAY_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            stb_q   <= stb_d;
`ifdef AUTOPLAY_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign page     = page_q;
    assign ena      = (state_q != ST_OFF);
    assign page_stb = stb_q;
`ifdef AUTOPLAY_EN
    assign auto_on  = (state_q == ST_AUTO);
`else
    assign auto_on  = 1'b0;
`endif
endmodule

// File: tb/tb_page_flip_controller.sv
// Bench for page_flip_controller: directed vector table, hand sequences and random traffic
// checked every cycle against a history-window reference model.

module tb_page_flip_controller;
    localparam int PC = 5;
    localparam int D  = 4;
    localparam int AP = 10;
    localparam int HW = D + 1;

    logic       clk = 1'b0;
    logic       rst, power_on, btn_next, btn_prev, btn_auto;
    logic [9:0] page, page1;
    logic       ena, page_stb, auto_on;
    logic       ena1, page_stb1, auto_on1;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;

    page_flip_controller #(.PAGE_COUNT(PC), .DEBOUNCE_CYC(D), .AUTO_PERIOD(AP)) u_dut (
        .clk100mhz(clk), .rst(rst), .power_on(power_on), .btn_next(btn_next),
        .btn_prev(btn_prev), .btn_auto(btn_auto), .page(page), .ena(ena),
        .page_stb(page_stb), .auto_on(auto_on)
    );

    page_flip_controller #(.PAGE_COUNT(1), .DEBOUNCE_CYC(D), .AUTO_PERIOD(AP)) u_dut1 (
        .clk100mhz(clk), .rst(rst), .power_on(power_on), .btn_next(btn_next),
        .btn_prev(btn_prev), .btn_auto(btn_auto), .page(page1), .ena(ena1),
        .page_stb(page_stb1), .auto_on(auto_on1)
    );

    always #5 clk = ~clk;

    // Reference model: raw-sample history per button, mode 0=OFF 1=SHOW 2=AUTO.
    bit hist [3][HW];
    bit m_lvl [3];
    bit m_rise [3];
    bit m_press [3];
    int m_page, m_mode, m_el;
    bit m_stb, m_entry;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < HW; i++) hist[b][i] = 1'b0;
            m_lvl[b] = 1'b0; m_rise[b] = 1'b0; m_press[b] = 1'b0;
        end
        m_page = 0; m_mode = 0; m_el = 0; m_stb = 1'b0; m_entry = 1'b0;
    endtask

    task automatic model_step();
        bit raw [3];
        bit pr [3];
        bit alld, nx, pv, au;
        int step, old;
        raw[0] = btn_next; raw[1] = btn_prev; raw[2] = btn_auto;
        if (rst) begin
            model_reset();
            return;
        end
        for (int b = 0; b < 3; b++) begin
            pr[b] = m_press[b];
            m_press[b] = m_rise[b];
            // level flips once the last D synced samples all disagree with it
            alld = 1'b1;
            for (int i = 1; i <= D; i++) if (hist[b][i] == m_lvl[b]) alld = 1'b0;
            m_rise[b] = 1'b0;
            if (alld) begin
                m_lvl[b] = !m_lvl[b];
                m_rise[b] = m_lvl[b];
            end
            for (int i = HW - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = raw[b];
        end
        nx = pr[0]; pv = pr[1]; au = 1'b0;
`ifdef AUTOPLAY_EN
        au = pr[2];
`endif
        m_entry = 1'b0;
        old = m_page;
        if (!power_on) begin
            m_mode = 0; m_el = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_page = 0; m_entry = 1'b1; m_el = 0;
        end else begin
            step = 0;
            if (nx && !pv) step = 1;
            else if (pv && !nx) step = -1;
            if (m_mode == 2) begin
                if (au) begin m_mode = 1; m_el = 0; end
                else if (step != 0) m_el = 0;
                else if (m_el == AP - 1) begin step = 1; m_el = 0; end
                else m_el++;
            end else if (au) begin
                m_mode = 2; m_el = 0;
            end
            m_page = (m_page + step + PC) % PC;
        end
        m_stb = m_entry || (m_page != old);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (page_stb) stb_cnt++;
        check("model_page", int'(page), m_page);
        check("model_ena", int'(ena), int'(m_mode != 0));
        check("model_stb", int'(page_stb), int'(m_stb));
        check("model_auto_on", int'(auto_on), int'(m_mode == 2));
        check("pc1_page", int'(page1), 0);
        check("pc1_stb", int'(page_stb1), int'(m_entry));
        check("pc1_ena", int'(ena1), int'(m_mode != 0));
    endtask

    task automatic wait_stb(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (page_stb) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct packed {
        bit nx;
        bit pv;
        bit au;
        int hold;
        int exp_page;
        int exp_stbs;
    } vec_t;

    vec_t vecs [8];
    int   n;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 3,  0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 20, 1, 1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 20, 0, 1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 20, 4, 1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 20, 0, 1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 20, 0, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 20, 1, 1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 20, 2, 1};

        model_reset();
        rst = 1'b1; power_on = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; btn_auto = 1'b0;
        tick(); tick();
        check("reset_page", int'(page), 0);
        check("reset_ena", int'(ena), 0);
        rst = 1'b0;

        power_on = 1'b1;
        tick();
        check("power_ena", int'(ena), 1);
        check("power_page", int'(page), 0);
        check("power_stb", int'(page_stb), 1);
        check("power_auto_on", int'(auto_on), 0);
        tick();
        check("power_stb_once", int'(page_stb), 0);

        for (int v = 0; v < 8; v++) begin
            stb_cnt = 0;
            btn_next = vecs[v].nx; btn_prev = vecs[v].pv; btn_auto = vecs[v].au;
            repeat (vecs[v].hold) tick();
            btn_next = 1'b0; btn_prev = 1'b0; btn_auto = 1'b0;
            repeat (12) tick();
            check($sformatf("vec%0d_page", v), int'(page), vecs[v].exp_page);
            check($sformatf("vec%0d_stbs", v), stb_cnt, vecs[v].exp_stbs);
        end

        // raw rise to page update latency
        btn_next = 1'b1;
        wait_stb(30, n);
        check("latency", n, D + 4);
        check("latency_page", int'(page), 3);
        btn_next = 1'b0;
        repeat (12) tick();

`ifdef AUTOPLAY_EN
        power_on = 1'b0; tick(); tick();
        power_on = 1'b1; tick();
        check("auto_start_page", int'(page), 0);
        btn_auto = 1'b1;
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (auto_on) begin n = i; break; end
        end
        check("auto_entry", n, D + 4);
        btn_auto = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_stb(20, n);
            check("auto_period", n, AP);
            check("auto_page", int'(page), k % PC);
        end
        btn_next = 1'b1;
        wait_stb(20, n);
        check("auto_manual_lat", n, D + 4);
        check("auto_manual_page", int'(page), 1);
        btn_next = 1'b0;
        wait_stb(20, n);
        check("auto_restart", n, AP);
        check("auto_restart_page", int'(page), 2);
        power_on = 1'b0;
        tick();
        check("off_ena", int'(ena), 0);
        check("off_auto_on", int'(auto_on), 0);
        check("off_page", int'(page), 2);
        stb_cnt = 0;
        repeat (5) tick();
        check("off_hold_page", int'(page), 2);
        check("off_no_stb", stb_cnt, 0);
        power_on = 1'b1; tick();
        btn_auto = 1'b1; repeat (9) tick(); btn_auto = 1'b0;
        check("auto_again", int'(auto_on), 1);
`endif

        btn_next = 1'b1;
        repeat (3) tick();
        rst = 1'b1; power_on = 1'b0;
        tick();
        check("rst_page", int'(page), 0);
        check("rst_ena", int'(ena), 0);
        check("rst_stb", int'(page_stb), 0);
        check("rst_auto_on", int'(auto_on), 0);
        tick();
        rst = 1'b0;
        repeat (15) tick();
        check("rst_off_page", int'(page), 0);
        power_on = 1'b1;
        tick();
        check("rst_on_stb", int'(page_stb), 1);
        check("rst_on_ena", int'(ena), 1);
        stb_cnt = 0;
        repeat (15) tick();
        check("held_no_press", stb_cnt, 0);
        check("held_page", int'(page), 0);
        btn_next = 1'b0;
        repeat (12) tick();
        btn_next = 1'b1;
        wait_stb(30, n);
        check("fresh_press_lat", n, D + 4);
        check("fresh_press_page", int'(page), 1);
        btn_next = 1'b0;
        repeat (12) tick();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 7) == 0) btn_prev = ~btn_prev;
            if ($urandom_range(0, 9) == 0) btn_auto = ~btn_auto;
            if (power_on) begin
                if ($urandom_range(0, 299) == 0) power_on = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                power_on = 1'b1;
            end
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
